sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Two-master (instruction / data) arbiter onto a single
//                SRAM-like port. At most one outstanding transaction. Data is
//                preferred, but a bounded run of data grants while the
//                instruction side waits forces an instruction grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    // instruction side
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data side
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // shared memory port
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [2:0] c_max_streak = 3'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_owner_data;       // 1 = data side owns the port, 0 = inst side
    logic [2:0] r_streak;
    logic [2:0] w_streak_next;
    logic       w_grant_data;
    logic       w_owner_data;
    logic       w_mem_req;
    logic       w_hs;
    logic       w_resp_done;

    // Fresh arbitration decision, only consulted while idle
    always_comb begin
        w_grant_data = data_req & ~(inst_req & (r_streak >= c_max_streak));
    end

    // Effective owner and port request: live decision in IDLE, locked otherwise
    always_comb begin
        w_owner_data = r_owner_data;
        w_mem_req    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_owner_data = w_grant_data;
                w_mem_req    = inst_req | data_req;
            end
            ST_ADDR: w_mem_req = 1'b1;
            default: w_mem_req = 1'b0;
        endcase
    end

    assign w_hs        = w_mem_req & mem_addr_ok;
    assign w_resp_done = (r_state == ST_RESP) & mem_data_ok;

    // Request fields come from the owner only while a request is presented
    always_comb begin
        mem_req   = w_mem_req;
        mem_wr    = 1'b0;
        mem_size  = 2'b00;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (w_mem_req) begin
            if (w_owner_data) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
        end
    end

    // Handshake and response routing back to the owning side only
    always_comb begin
        inst_addr_ok = w_hs & ~w_owner_data;
        data_addr_ok = w_hs &  w_owner_data;
        inst_data_ok = w_resp_done & ~r_owner_data;
        data_data_ok = w_resp_done &  r_owner_data;
        inst_rdata   = (w_resp_done & ~r_owner_data) ? mem_rdata : 32'h0;
        data_rdata   = (w_resp_done &  r_owner_data) ? mem_rdata : 32'h0;
        busy         = (r_state != ST_IDLE);
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hs)
                    w_state_next = ST_RESP;
                else if (w_mem_req)
                    w_state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (w_hs)
                    w_state_next = ST_RESP;
            end
            ST_RESP: begin
                if (mem_data_ok)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Streak update: count data grants taken while inst waits, clear on inst grant
    always_comb begin
        w_streak_next = r_streak;
        if (w_hs) begin
            if (!w_owner_data)
                w_streak_next = 3'd0;
            else if (inst_req && (r_streak < c_max_streak))
                w_streak_next = r_streak + 3'd1;
        end
    end

    // State, owner lock and streak registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner_data <= 1'b1;
            r_streak     <= 3'd0;
        end else begin
            r_state  <= w_state_next;
            r_streak <= w_streak_next;
            if ((r_state == ST_IDLE) && w_mem_req)
                r_owner_data <= w_owner_data;
        end
    end

endmodule
`default_nettype wire
